// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame assembler.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2
  } state_t;

  localparam int          FRAME_LEN    = 3;
  localparam logic [15:0] TIMEOUT_DFLT = 16'd5000;

endpackage

// File: rtl/frm_tmr.sv
// Inter-byte idle timer: counts idle cycles inside a frame, flags expiry at TIMEOUT-1.
module frm_tmr #(
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // TIMEOUT of 0 or 1 both mean "expire on the first idle cycle"; count saturates, never wraps.
  localparam logic [15:0] LIMIT = (TIMEOUT <= 16'd1) ? 16'd0 : TIMEOUT - 16'd1;

  logic [15:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= 16'd0;
    end else if (en && (cnt_reg != LIMIT)) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign expired = en && (cnt_reg == LIMIT);

endmodule

// File: rtl/uart_cmd_assm.sv
// Assembles 3-byte UART frames (opcode, data_hi, data_lo) into a held command with ack.
module uart_cmd_assm
  import uart_cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_byte,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [7:0]  opcode,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        frm_err,
  output logic        ovr
);

  state_t      state_reg, state_next;
  logic        accept, expired, tmr_clr, tmr_en;
  logic        cap_op, cap_hi, complete, timeout;
  logic [7:0]  op_sh_reg, hi_sh_reg;
  logic [7:0]  opcode_reg;
  logic [15:0] data_reg;
  logic        cmd_rdy_reg, frm_err_reg, ovr_reg;

  // Bytes are taken the moment they appear, even in reset, so the receiver never stalls.
  assign accept     = rx_rdy;
  assign clr_rx_rdy = rx_rdy;

  assign tmr_clr = accept || (state_reg == WAIT_B0);
  assign tmr_en  = (state_reg != WAIT_B0);

  frm_tmr #(.TIMEOUT(TIMEOUT)) u_frm_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= WAIT_B0;
    else     state_reg <= state_next;
  end

  // An accept always takes priority over a coincident timeout.
  always_comb begin
    state_next = state_reg;
    cap_op     = 1'b0;
    cap_hi     = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      WAIT_B0: begin
        if (accept) begin
          cap_op     = 1'b1;
          state_next = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (accept) begin
          cap_hi     = 1'b1;
          state_next = WAIT_B2;
        end else if (expired) begin
          timeout    = 1'b1;
          state_next = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (accept) begin
          complete   = 1'b1;
          state_next = WAIT_B0;
        end else if (expired) begin
          timeout    = 1'b1;
          state_next = WAIT_B0;
        end
      end
      default: state_next = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_sh_reg   <= 8'h00;
      hi_sh_reg   <= 8'h00;
      opcode_reg  <= 8'h00;
      data_reg    <= 16'h0000;
      cmd_rdy_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      ovr_reg     <= 1'b0;
    end else begin
      frm_err_reg <= timeout;
      ovr_reg     <= complete && cmd_rdy_reg && !clr_cmd_rdy;
      if (cap_op) op_sh_reg <= rx_byte;
      if (cap_hi) hi_sh_reg <= rx_byte;
      // Completion beats a same-cycle acknowledge: the fresh command stays pending.
      if (complete) begin
        opcode_reg  <= op_sh_reg;
        data_reg    <= {hi_sh_reg, rx_byte};
        cmd_rdy_reg <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy_reg <= 1'b0;
      end
    end
  end

  assign opcode  = opcode_reg;
  assign data    = data_reg;
  assign cmd_rdy = cmd_rdy_reg;
  assign frm_err = frm_err_reg;
  assign ovr     = ovr_reg;

endmodule

// File: tb/tb_uart_cmd_assm.sv
// Randomized + directed scoreboard bench for uart_cmd_assm with a frame-level reference model.
module tb_uart_cmd_assm;
  import uart_cmd_pkg::*;

  localparam logic [15:0] TMO = 16'd10;
  localparam int TMO_EFF = (TMO <= 16'd1) ? 1 : int'(TMO);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        clr_rx_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  opcode;
  logic [15:0] data;
  logic        cmd_rdy, frm_err, ovr;

  uart_cmd_assm #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_byte     (rx_byte),
    .clr_rx_rdy  (clr_rx_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .opcode      (opcode),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err),
    .ovr         (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        frm_err;
    logic        ovr;
    logic        cmd_rdy;
    logic [7:0]  op;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: the command a consumer would see, plus the bytes of the open frame.
  logic [7:0]  m_op = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_rdy = 1'b0;
  logic [7:0]  m_frame[$];
  int          m_idle = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, expv);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare each against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frm_err", {31'd0, frm_err}, {31'd0, e.frm_err});
        chk("ovr",     {31'd0, ovr},     {31'd0, e.ovr});
        chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, e.cmd_rdy});
        chk("opcode",  {24'd0, opcode},  {24'd0, e.op});
        chk("data",    {16'd0, data},    {16'd0, e.data});
      end
    end
  end

  // One clock of stimulus; the model predicts what the outputs show after the coming edge.
  task automatic step(input logic r, input logic v, input logic [7:0] b, input logic c);
    exp_t e;
    logic done;
    @(negedge clk);
    rst = r; rx_rdy = v; rx_byte = b; clr_cmd_rdy = c;
    #1;
    chk("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, v});
    e.frm_err = 1'b0;
    e.ovr = 1'b0;
    done = 1'b0;
    if (r) begin
      m_op = 8'h00; m_data = 16'h0000; m_rdy = 1'b0;
      m_frame.delete(); m_idle = 0;
    end else if (v) begin
      m_frame.push_back(b);
      m_idle = 0;
      if (m_frame.size() == FRAME_LEN) begin
        done = 1'b1;
        e.ovr = m_rdy && !c;
        m_op = m_frame[0];
        m_data = {m_frame[1], m_frame[2]};
        m_rdy = 1'b1;
        m_frame.delete();
      end
    end else if (m_frame.size() > 0) begin
      m_idle++;
      if (m_idle >= TMO_EFF) begin
        e.frm_err = 1'b1;
        m_frame.delete();
        m_idle = 0;
      end
    end
    if (!r && !done && c) m_rdy = 1'b0;
    e.cmd_rdy = m_rdy;
    e.op = m_op;
    e.data = m_data;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input logic c);
    step(1'b0, 1'b1, b, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ack();
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int r;
    // Reset, with a stale byte present that must still be drained.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Basic frame, bytes two cycles apart, then acknowledge.
    send(8'hA5, 1'b0); idle(1); send(8'h12, 1'b0); idle(1); send(8'h34, 1'b0);
    idle(2); ack(); idle(1);

    // Timeout after one byte, then a clean frame.
    send(8'h01, 1'b0); idle(12);
    send(8'h02, 1'b0); send(8'hAB, 1'b0); send(8'hCD, 1'b0);
    idle(1); ack();

    // Third byte lands exactly on the timeout cycle.
    send(8'h11, 1'b0); send(8'h22, 1'b0); idle(TMO_EFF - 1); send(8'h33, 1'b0);
    idle(1); ack();

    // Second byte on the timeout cycle as well.
    send(8'h44, 1'b0); idle(TMO_EFF - 1); send(8'h45, 1'b0); send(8'h46, 1'b0);

    // Overrun: another frame while the previous is still pending.
    send(8'h60, 1'b0); send(8'h61, 1'b0); send(8'h62, 1'b0);
    idle(2); ack(); idle(1);

    // Acknowledge coincident with completion.
    send(8'h70, 1'b0); send(8'h71, 1'b0); send(8'h72, 1'b0);
    send(8'h80, 1'b0); send(8'h81, 1'b0); send(8'h82, 1'b1);
    idle(1); ack();

    // Reset mid-frame, then a fresh frame.
    send(8'h90, 1'b0); send(8'h91, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    send(8'h7E, 1'b0); send(8'h00, 1'b0); send(8'hFF, 1'b0);
    idle(TMO_EFF + 2); ack();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)       step(1'b1, 1'(($urandom_range(0, 1))), 8'($urandom), 1'b0);
      else if (r < 50) send(8'($urandom), 1'($urandom_range(0, 9) == 0));
      else if (r < 55) idle(int'($urandom_range(TMO_EFF - 2, TMO_EFF + 2)));
      else             step(1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 7) == 0));
    end

    idle(3);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
